// File: rtl/encoder_code_capture.sv
// rtl/encoder_code_capture.sv - qualifies stable priority-encoder codes into a small valid/ready FIFO
module encoder_code_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4:0]                    enc_z_n,
  input  logic                          enc_gs_n,
  input  logic                          code_ready,
  output logic                          code_valid,
  output logic [4:0]                    code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(STABLE_CYCLES + 1);
  localparam logic [NW-1:0] CNT_MAX = NW'(STABLE_CYCLES);
  localparam logic [NW-1:0] CNT_ONE = NW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  logic [4:0]    z_q;
  logic          gs_q;
  logic [4:0]    idx;
  state_t        state, state_n;
  logic [NW-1:0] cnt, cnt_n;
  logic [4:0]    cur_idx, cur_n;
  logic          push;
  logic [4:0]    push_data;
  logic          restart;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en;

  assign idx = ~z_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q  <= 5'h1f;
      gs_q <= 1'b1;
    end else begin
      z_q  <= enc_z_n;
      gs_q <= enc_gs_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= 5'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_idx <= cur_n;
    end
  end

  // restart = a new index starts its qualification window (count 1 already)
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cur_n     = cur_idx;
    push      = 1'b0;
    push_data = cur_idx;
    restart   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!gs_q) restart = 1'b1;
        end
        SETTLE: begin
          if (gs_q) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (idx != cur_idx) begin
            restart = 1'b1;
          end else if ((cnt + CNT_ONE) == CNT_MAX) begin
            push    = 1'b1;
            state_n = HELD;
            cnt_n   = CNT_MAX;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (gs_q) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (idx != cur_idx) begin
            restart = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
      if (restart) begin
        cur_n = idx;
        cnt_n = CNT_ONE;
        if (STABLE_CYCLES == 1) begin
          push      = 1'b1;
          push_data = idx;
          state_n   = HELD;
        end else begin
          state_n = SETTLE;
        end
      end
    end
  end

  assign full       = (count == FULL_CNT);
  assign code_valid = (count != '0);
  assign pop        = code_valid & code_ready;
  assign wr_en      = push & (~full | pop);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // code is a register so it can hold the last head after the FIFO drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      code     <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) begin
        if (count > CW'(1)) code <= mem[rd_ptr + AW'(1)];
        else if (wr_en) code <= push_data;
      end else if (wr_en && count == '0) begin
        code <= push_data;
      end
    end
  end

endmodule
